// File: rtl/connector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connector_pkg
// Description : Shared types for the commit-to-trace connector: the CVA6
//               functional-unit operation code, the serialized commit entry
//               and the commit_sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package connector_pkg;

    localparam int c_XLEN      = 64;
    localparam int c_CAUSE_LEN = 5;

    // Operation class reported on each commit port.
    typedef enum logic [7:0] {
        ADD   = 8'd0,
        SUB   = 8'd1,
        LOAD  = 8'd2,
        STORE = 8'd3,
        BEQ   = 8'd4,
        JAL   = 8'd5,
        JALR  = 8'd6,
        CSRRW = 8'd7
    } fu_op;

    // One serialized commit record as seen by the encoder.
    typedef struct packed {
        logic [c_XLEN-1:0]      pc;
        fu_op                   op;
        logic                   is_compressed;
        logic                   branch_taken;
        logic                   exception;
        logic                   interrupt;
        logic [c_CAUSE_LEN-1:0] cause;
        logic [c_XLEN-1:0]      tval;
        logic                   resync;
    } commit_entry_t;

    // Explicit one-bit encoding of the sequencer FSM.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_multi_push.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_multi_push
// Description : Synchronous FIFO accepting up to MAX_PUSH entries per cycle
//               and releasing one entry per cycle. Storage is reset so the
//               head reads as zero when empty after reset.
// Ports       : clk_i, rst_ni      - clock, async active-low reset
//               push_i[MAX_PUSH]   - per-slot write enables (contiguous from 0)
//               push_data_i        - per-slot write data
//               pop_i              - consume the head (caller guarantees fill>0)
//               head_o             - entry at the read pointer
//               fill_o             - occupancy, $clog2(DEPTH)+1 bits
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_multi_push #(
    parameter type T        = logic,
    parameter int  DEPTH    = 8,
    parameter int  MAX_PUSH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [MAX_PUSH-1:0]      push_i,
    input  T     [MAX_PUSH-1:0]      push_data_i,
    input  logic                     pop_i,
    output T                         head_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_FW = c_PW + 1;

    T                r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_FW-1:0] r_fill;
    logic [c_FW-1:0] w_push_cnt;

    always_comb begin
        w_push_cnt = '0;
        for (int k = 0; k < MAX_PUSH; k++) begin
            w_push_cnt = w_push_cnt + c_FW'(push_i[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            // Write slot k lands k entries past the write pointer; the
            // pointer arithmetic wraps naturally modulo DEPTH.
            for (int k = 0; k < MAX_PUSH; k++) begin
                if (push_i[k]) begin
                    r_mem[r_wr_ptr + c_PW'(k)] <= push_data_i[k];
                end
            end
            r_wr_ptr <= r_wr_ptr + c_PW'(w_push_cnt);
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_fill <= r_fill + w_push_cnt - c_FW'(pop_i);
        end
    end

    assign head_o = r_mem[r_rd_ptr];
    assign fill_o = r_fill;

endmodule
`default_nettype wire

// File: rtl/commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : commit_sequencer
// Description : Serializes up to NRET commits per cycle (plus trap info) into
//               a one-entry-per-cycle valid/ready stream. Bundles are pushed
//               whole or dropped; after a drop the FIFO is drained and the
//               next accepted entry is tagged for encoder resync.
// Ports       : clk_i, rst_ni                     - clock, async active-low reset
//               valid_i/pc_i/op_i/is_compressed_i/branch_taken_i - commit ports
//               exception_i/interrupt_i/cause_i/tval_i           - trap info
//               ready_i                           - downstream accepts head
//               valid_o + head fields, resync_o   - serialized stream
//               overflow_o                        - sticky bundle-drop flag
//               fill_o                            - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module commit_sequencer
    import connector_pkg::*;
#(
    parameter int NRET      = 2,
    parameter int DEPTH     = 8,
    parameter int XLEN      = 64,
    parameter int CAUSE_LEN = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NRET-1:0]               valid_i,
    input  logic [NRET-1:0][XLEN-1:0]     pc_i,
    input  fu_op [NRET-1:0]               op_i,
    input  logic [NRET-1:0]               is_compressed_i,
    input  logic [NRET-1:0]               branch_taken_i,
    input  logic                          exception_i,
    input  logic                          interrupt_i,
    input  logic [CAUSE_LEN-1:0]          cause_i,
    input  logic [XLEN-1:0]               tval_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [XLEN-1:0]               pc_o,
    output fu_op                          op_o,
    output logic                          is_compressed_o,
    output logic                          branch_taken_o,
    output logic                          exception_o,
    output logic                          interrupt_o,
    output logic [CAUSE_LEN-1:0]          cause_o,
    output logic [XLEN-1:0]               tval_o,
    output logic                          resync_o,
    output logic                          overflow_o,
    output logic [$clog2(DEPTH):0]        fill_o
);

    localparam int c_FW = $clog2(DEPTH) + 1;

    commit_entry_t [NRET-1:0] w_bundle;
    logic [NRET-1:0]          w_bundle_vld;
    logic [NRET-1:0]          w_push;
    logic [c_FW-1:0]          w_n;
    logic [c_FW-1:0]          w_fill;
    logic [c_FW-1:0]          w_free;
    logic                     w_pop;
    logic                     w_space_ok;
    commit_entry_t            w_head;

    seq_state_e               r_state;
    seq_state_e               w_state_next;
    logic                     r_resync_armed;
    logic                     w_resync_next;
    logic                     r_overflow;
    logic                     w_overflow_next;

    // Bundle formation: a trap collapses the cycle into a single port-0
    // entry; otherwise valid ports are packed toward slot 0 in port order.
    always_comb begin
        int idx;
        idx          = 0;
        w_bundle     = '0;
        w_bundle_vld = '0;
        if (exception_i || interrupt_i) begin
            w_bundle[0].pc            = pc_i[0];
            w_bundle[0].op            = op_i[0];
            w_bundle[0].is_compressed = is_compressed_i[0];
            w_bundle[0].branch_taken  = branch_taken_i[0];
            w_bundle[0].exception     = exception_i;
            w_bundle[0].interrupt     = interrupt_i;
            w_bundle[0].cause         = cause_i;
            w_bundle[0].tval          = tval_i;
            w_bundle_vld[0]           = 1'b1;
        end else begin
            for (int p = 0; p < NRET; p++) begin
                if (valid_i[p]) begin
                    for (int s = 0; s < NRET; s++) begin
                        if (s == idx) begin
                            w_bundle[s].pc            = pc_i[p];
                            w_bundle[s].op            = op_i[p];
                            w_bundle[s].is_compressed = is_compressed_i[p];
                            w_bundle[s].branch_taken  = branch_taken_i[p];
                            w_bundle_vld[s]           = 1'b1;
                        end
                    end
                    idx = idx + 1;
                end
            end
        end
        // Only the first entry of a bundle can carry the resync tag.
        w_bundle[0].resync = r_resync_armed;
    end

    always_comb begin
        w_n = '0;
        for (int s = 0; s < NRET; s++) begin
            w_n = w_n + c_FW'(w_bundle_vld[s]);
        end
    end

    // Space is judged after this cycle's pop, so a full FIFO that is
    // popping can still take a one-entry bundle.
    assign w_pop      = (w_fill != '0) && ready_i;
    assign w_free     = c_FW'(DEPTH) - w_fill + c_FW'(w_pop);
    assign w_space_ok = (w_free >= w_n);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= RUN;
            r_resync_armed <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_resync_armed <= w_resync_next;
            r_overflow     <= w_overflow_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_push          = '0;
        w_resync_next   = r_resync_armed;
        w_overflow_next = r_overflow;
        case (r_state)
            RUN: begin
                if (w_n != '0) begin
                    if (w_space_ok) begin
                        w_push        = w_bundle_vld;
                        w_resync_next = 1'b0;
                    end else begin
                        w_overflow_next = 1'b1;
                        w_state_next    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Everything offered while draining is discarded.
                if (w_fill == '0) begin
                    w_state_next  = RUN;
                    w_resync_next = 1'b1;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    sync_fifo_multi_push #(
        .T        (commit_entry_t),
        .DEPTH    (DEPTH),
        .MAX_PUSH (NRET)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (w_bundle),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .fill_o      (w_fill)
    );

    assign valid_o         = (w_fill != '0);
    assign pc_o            = w_head.pc;
    assign op_o            = w_head.op;
    assign is_compressed_o = w_head.is_compressed;
    assign branch_taken_o  = w_head.branch_taken;
    assign exception_o     = w_head.exception;
    assign interrupt_o     = w_head.interrupt;
    assign cause_o         = w_head.cause;
    assign tval_o          = w_head.tval;
    assign resync_o        = w_head.resync;
    assign overflow_o      = r_overflow;
    assign fill_o          = w_fill;

endmodule
`default_nettype wire

// File: tb/tb_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_sequencer
// Description : Directed self-checking bench for commit_sequencer
//               (NRET=2, DEPTH=8, XLEN=64, CAUSE_LEN=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_sequencer;
    import connector_pkg::*;

    logic             clk;
    logic             rst_ni;
    logic [1:0]       valid_i;
    logic [1:0][63:0] pc_i;
    fu_op [1:0]       op_i;
    logic [1:0]       is_compressed_i;
    logic [1:0]       branch_taken_i;
    logic             exception_i;
    logic             interrupt_i;
    logic [4:0]       cause_i;
    logic [63:0]      tval_i;
    logic             ready_i;
    logic             valid_o;
    logic [63:0]      pc_o;
    fu_op             op_o;
    logic             is_compressed_o;
    logic             branch_taken_o;
    logic             exception_o;
    logic             interrupt_o;
    logic [4:0]       cause_o;
    logic [63:0]      tval_o;
    logic             resync_o;
    logic             overflow_o;
    logic [3:0]       fill_o;

    int n_chk  = 0;
    int n_fail = 0;

    commit_sequencer #(
        .NRET(2), .DEPTH(8), .XLEN(64), .CAUSE_LEN(5)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .valid_i         (valid_i),
        .pc_i            (pc_i),
        .op_i            (op_i),
        .is_compressed_i (is_compressed_i),
        .branch_taken_i  (branch_taken_i),
        .exception_i     (exception_i),
        .interrupt_i     (interrupt_i),
        .cause_i         (cause_i),
        .tval_i          (tval_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .pc_o            (pc_o),
        .op_o            (op_o),
        .is_compressed_o (is_compressed_o),
        .branch_taken_o  (branch_taken_o),
        .exception_o     (exception_o),
        .interrupt_o     (interrupt_o),
        .cause_o         (cause_o),
        .tval_o          (tval_o),
        .resync_o        (resync_o),
        .overflow_o      (overflow_o),
        .fill_o          (fill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [1:0] v, input logic [63:0] p0,
                              input logic [63:0] p1, input logic exc,
                              input logic intr, input logic [4:0] cause,
                              input logic [63:0] tval);
        valid_i     = v;
        pc_i[0]     = p0;
        pc_i[1]     = p1;
        exception_i = exc;
        interrupt_i = intr;
        cause_i     = cause;
        tval_i      = tval;
    endtask

    task automatic clear_inputs();
        set_bundle(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        op_i[0]         = ADD;
        op_i[1]         = ADD;
        is_compressed_i = 2'b00;
        branch_taken_i  = 2'b00;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        ready_i = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", valid_o); end
        n_chk++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", fill_o); end
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b exp 0", overflow_o); end
        n_chk++; if (resync_o !== 1'b0) begin n_fail++; $display("FAIL reset_resync got %0b exp 0", resync_o); end
        n_chk++; if (pc_o !== 64'h0 || cause_o !== 5'd0) begin n_fail++; $display("FAIL reset_data got pc=%0h cause=%0d exp 0/0", pc_o, cause_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_dual_commit();
        ready_i = 1'b1;
        set_bundle(2'b11, 64'h100, 64'h104, 1'b0, 1'b0, 5'd0, 64'h0);
        op_i[0] = JAL; op_i[1] = BEQ;
        is_compressed_i = 2'b01; branch_taken_i = 2'b10;
        tick();
        clear_inputs();
        n_chk++; if (valid_o !== 1'b1 || fill_o !== 4'd2) begin n_fail++; $display("FAIL dual_first_fill got v=%0b f=%0d exp 1/2", valid_o, fill_o); end
        n_chk++; if (pc_o !== 64'h100) begin n_fail++; $display("FAIL dual_first_pc got %0h exp 100", pc_o); end
        n_chk++; if (op_o !== JAL || is_compressed_o !== 1'b1 || branch_taken_o !== 1'b0) begin n_fail++; $display("FAIL dual_first_fields got op=%0d c=%0b b=%0b exp 5/1/0", op_o, is_compressed_o, branch_taken_o); end
        tick();
        n_chk++; if (pc_o !== 64'h104 || fill_o !== 4'd1) begin n_fail++; $display("FAIL dual_second got pc=%0h f=%0d exp 104/1", pc_o, fill_o); end
        n_chk++; if (op_o !== BEQ || is_compressed_o !== 1'b0 || branch_taken_o !== 1'b1) begin n_fail++; $display("FAIL dual_second_fields got op=%0d c=%0b b=%0b exp 4/0/1", op_o, is_compressed_o, branch_taken_o); end
        tick();
        n_chk++; if (valid_o !== 1'b0 || fill_o !== 4'd0) begin n_fail++; $display("FAIL dual_empty got v=%0b f=%0d exp 0/0", valid_o, fill_o); end
    endtask

    task automatic test_port1_only();
        ready_i = 1'b1;
        // cause/tval without a trap must be stored as zero.
        set_bundle(2'b10, 64'hDEAD, 64'h200, 1'b0, 1'b0, 5'd7, 64'h99);
        tick();
        clear_inputs();
        n_chk++; if (valid_o !== 1'b1 || fill_o !== 4'd1 || pc_o !== 64'h200) begin n_fail++; $display("FAIL port1_entry got v=%0b f=%0d pc=%0h exp 1/1/200", valid_o, fill_o, pc_o); end
        n_chk++; if (cause_o !== 5'd0 || tval_o !== 64'h0 || exception_o !== 1'b0) begin n_fail++; $display("FAIL port1_notrap got cause=%0d tval=%0h exc=%0b exp 0/0/0", cause_o, tval_o, exception_o); end
        tick();
        n_chk++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL port1_empty got %0d exp 0", fill_o); end
    endtask

    task automatic test_exception();
        ready_i = 1'b1;
        set_bundle(2'b11, 64'h300, 64'h304, 1'b1, 1'b0, 5'd2, 64'h55);
        tick();
        clear_inputs();
        n_chk++; if (fill_o !== 4'd1 || pc_o !== 64'h300) begin n_fail++; $display("FAIL exc_entry got f=%0d pc=%0h exp 1/300", fill_o, pc_o); end
        n_chk++; if (exception_o !== 1'b1 || interrupt_o !== 1'b0 || cause_o !== 5'd2 || tval_o !== 64'h55) begin n_fail++; $display("FAIL exc_fields got e=%0b i=%0b c=%0d t=%0h exp 1/0/2/55", exception_o, interrupt_o, cause_o, tval_o); end
        tick();
        n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL exc_port1_dropped got v=%0b pc=%0h exp 0", valid_o, pc_o); end
        // Interrupt without any valid commit still forms one entry.
        set_bundle(2'b00, 64'h340, 64'h0, 1'b0, 1'b1, 5'd5, 64'h0);
        tick();
        clear_inputs();
        n_chk++; if (fill_o !== 4'd1 || pc_o !== 64'h340 || interrupt_o !== 1'b1 || exception_o !== 1'b0 || cause_o !== 5'd5) begin n_fail++; $display("FAIL irq_entry got f=%0d pc=%0h i=%0b e=%0b c=%0d exp 1/340/1/0/5", fill_o, pc_o, interrupt_o, exception_o, cause_o); end
        tick();
    endtask

    task automatic test_full_with_pop();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_bundle(2'b11, 64'h500 + 64'(8 * i), 64'h504 + 64'(8 * i), 1'b0, 1'b0, 5'd0, 64'h0);
            tick();
        end
        n_chk++; if (fill_o !== 4'd8 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL full_fill got f=%0d ov=%0b exp 8/0", fill_o, overflow_o); end
        n_chk++; if (pc_o !== 64'h500) begin n_fail++; $display("FAIL full_head_stable got %0h exp 500", pc_o); end
        ready_i = 1'b1;
        set_bundle(2'b01, 64'h600, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        clear_inputs();
        n_chk++; if (fill_o !== 4'd8 || overflow_o !== 1'b0 || pc_o !== 64'h504) begin n_fail++; $display("FAIL full_pop_push got f=%0d ov=%0b pc=%0h exp 8/0/504", fill_o, overflow_o, pc_o); end
        repeat (7) tick();
        n_chk++; if (fill_o !== 4'd1 || pc_o !== 64'h600) begin n_fail++; $display("FAIL full_last_entry got f=%0d pc=%0h exp 1/600", fill_o, pc_o); end
        tick();
    endtask

    task automatic test_overflow();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_bundle(2'b11, 64'h1000 + 64'(16 * i), 64'h1004 + 64'(16 * i), 1'b0, 1'b0, 5'd0, 64'h0);
            tick();
        end
        n_chk++; if (fill_o !== 4'd8 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_prefill got f=%0d ov=%0b exp 8/0", fill_o, overflow_o); end
        set_bundle(2'b11, 64'h2000, 64'h2004, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        n_chk++; if (overflow_o !== 1'b1 || fill_o !== 4'd8 || pc_o !== 64'h1000) begin n_fail++; $display("FAIL ovf_flag got ov=%0b f=%0d pc=%0h exp 1/8/1000", overflow_o, fill_o, pc_o); end
        // While draining, offered bundles are discarded even with space.
        ready_i = 1'b1;
        set_bundle(2'b01, 64'h3000, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        n_chk++; if (fill_o !== 4'd7 || pc_o !== 64'h1004) begin n_fail++; $display("FAIL drain_drop got f=%0d pc=%0h exp 7/1004", fill_o, pc_o); end
        repeat (7) tick();
        n_chk++; if (fill_o !== 4'd0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty got f=%0d v=%0b exp 0/0", fill_o, valid_o); end
        tick();
        n_chk++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL drain_exit_drop got %0d exp 0", fill_o); end
        set_bundle(2'b11, 64'h4000, 64'h4004, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        clear_inputs();
        n_chk++; if (fill_o !== 4'd2 || pc_o !== 64'h4000 || resync_o !== 1'b1) begin n_fail++; $display("FAIL resync_first got f=%0d pc=%0h rs=%0b exp 2/4000/1", fill_o, pc_o, resync_o); end
        n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", overflow_o); end
        tick();
        n_chk++; if (pc_o !== 64'h4004 || resync_o !== 1'b0 || fill_o !== 4'd1) begin n_fail++; $display("FAIL resync_second got pc=%0h rs=%0b f=%0d exp 4004/0/1", pc_o, resync_o, fill_o); end
        tick();
        n_chk++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL ovf_final_empty got %0d exp 0", fill_o); end
    endtask

    task automatic test_reset_mid_stream();
        ready_i = 1'b0;
        set_bundle(2'b11, 64'h700, 64'h704, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        set_bundle(2'b11, 64'h708, 64'h70C, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        set_bundle(2'b01, 64'h710, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        clear_inputs();
        n_chk++; if (fill_o !== 4'd5 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got f=%0d ov=%0b exp 5/1", fill_o, overflow_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_chk++; if (valid_o !== 1'b0 || fill_o !== 4'd0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_reset got v=%0b f=%0d ov=%0b exp 0/0/0", valid_o, fill_o, overflow_o); end
        n_chk++; if (pc_o !== 64'h0) begin n_fail++; $display("FAIL mid_reset_data got %0h exp 0", pc_o); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_dual_commit();
        test_port1_only();
        test_exception();
        test_full_with_pop();
        test_overflow();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_sequencer.md
# commit_sequencer

Serializes the CVA6 commit interface (up to NRET instructions per cycle plus exception/interrupt) into a one-entry-per-cycle stream for the single itype detector and trace encoder downstream. Ordering is preserved through a small FIFO. A valid/ready handshake on the output absorbs encoder stalls. On overflow, the block drains the FIFO and then tags the next accepted entry for encoder resynchronization.

## Interface
Parameters:
- NRET, 2: commit ports sampled per cycle (1 or 2).
- DEPTH, 8: FIFO entries (power of two, ≥ 2·NRET).
- XLEN, 64: PC / tval width.
- CAUSE_LEN, 5: cause width.

Ports (`clk_i` is the only clock; `rst_ni` is asynchronous, active-low):
- clk_i in 1: clock.
- rst_ni in 1: async active-low reset.
- valid_i in NRET: per-port commit valid.
- pc_i in NRET×XLEN: per-port committed PC.
- op_i in NRET×connector_pkg::fu_op: per-port operation.
- is_compressed_i in NRET: per-port 16-bit instruction flag.
- branch_taken_i in NRET: per-port branch outcome.
- exception_i in 1: exception on port 0 this cycle.
- interrupt_i in 1: interrupt this cycle.
- cause_i in CAUSE_LEN: exception/interrupt cause.
- tval_i in XLEN: trap value.
- ready_i in 1: downstream accepts the head entry.
- valid_o out 1: head entry present.
- pc_o, op_o, is_compressed_o, branch_taken_o, exception_o, interrupt_o, cause_o, tval_o out: head entry fields.
- resync_o out 1: head entry is the first one accepted after an overflow.
- overflow_o out 1: sticky; a bundle was dropped since reset.
- fill_o out $clog2(DEPTH)+1: current occupancy.

## Operation
- Bundle formation, per cycle:
  - If exception_i or interrupt_i is set: exactly one entry, carrying port-0 fields plus the flags, cause and tval; valid_i[0] is not required. Port 1 is ignored.
  - Otherwise: one entry per set valid_i bit, compacted in port order (port 0 first). If only port 1 is valid, it is written to the first free slot. Exception, interrupt, cause and tval are stored as 0.
  - N = number of entries in the bundle (0..NRET).
- Push rule:
  - A bundle is accepted whole only if free slots ≥ N, evaluated after that cycle's pop.
  - A bundle is never split.
- FSM states: RUN, DRAIN.
  - RUN, N>0, insufficient space: drop the whole bundle, set overflow_o, go to DRAIN.
  - DRAIN: all bundles are dropped. When fill reaches 0, go to RUN and arm the resync flag.
  - RUN with resync armed: the first entry of the next accepted bundle is stored with resync=1, then the flag is cleared. Other entries in that bundle get resync=0.
- Pop: occurs when valid_o && ready_i. Push and pop in the same cycle are both applied.
- Pointers: read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. Occupancy is a separate counter: fill_next = fill + N_accepted − pop.
- Output fields come combinationally from the head storage entry. valid_o = (fill != 0).

## Timing
- Reset values:
  - FSM = RUN; pointers, fill_o and resync flag = 0.
  - valid_o = 0, overflow_o = 0, resync_o = 0.
  - All data outputs = 0 (storage is reset).
- Latency: an entry accepted at edge k appears on valid_o in the cycle after edge k. There is no same-cycle bypass.
- Throughput: 1 pop per cycle. A 2-entry bundle is emitted over 2 consecutive cycles if ready_i stays high.
- Full FIFO with simultaneous pop: the freed slot counts toward space for that cycle's push.
- ready_i is ignored while valid_o=0. The head is stable while valid_o && !ready_i.
- Async reset mid-operation: all state clears immediately, overflow_o included.

## Structure
- connector_pkg: add commit_entry_t (pc, op, is_compressed, branch_taken, exception, interrupt, cause, tval, resync) and the state enum {RUN, DRAIN}.
- One sub-module: sync_fifo_multi_push, parameterized in entry type, DEPTH and max pushes per cycle. It owns storage, pointers and fill.
- commit_sequencer contains bundle compaction, the push-acceptance check, the FSM and the resync flag.
- The itype detector is instantiated by the parent on the output stream, not inside this block.

## Test plan
- Dual commit, ready_i=1: valid_i=2'b11, pc 0x100/0x104 → valid_o for 2 cycles, pc_o 0x100 then 0x104; fill_o goes 2→1→0.
- Port 1 only: valid_i=2'b10, pc_i[1]=0x200 → one entry, pc_o=0x200 the next cycle.
- Exception with both valid: exception_i=1, cause=2, valid_i=2'b11 → single entry with port-0 PC, exception_o=1, cause_o=2; port 1 is dropped.
- Overflow: ready_i=0, DEPTH=8, push 4 dual bundles (fill=8), then another → overflow_o=1, state DRAIN. Later bundles are dropped until fill=0. The first entry accepted afterwards has resync_o=1, the next has 0.
- Full with pop: fill=8, ready_i=1, 1-entry bundle → accepted, fill stays 8, no overflow.
- Reset mid-stream: fill=5, overflow_o=1, deassert rst_ni → valid_o=0, fill_o=0, overflow_o=0 asynchronously.
